// File: rtl/srt4_cu_param.sv
// Control unit for a radix-4 SRT divider, parametrised in operand width W.
// Sequences load, normalise, W/2 digit iterations, correction, conversion, denormalise and write-out.
module srt4_cu_param #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 beginSignal,
  input  logic                 abort,
  input  logic                 b_msb,
  input  logic                 b_zero,
  input  logic [2:0]           qdigit,
  input  logic                 p_sign,
  output logic                 busy,
  output logic                 endSignal,
  output logic                 dbz,
  output logic [4:0]           state,
  output logic [$clog2(W)-1:0] norm_cnt,
  output logic [16:0]          control_signals
);

  localparam int CW   = $clog2(W);
  localparam int ITER = W / 2;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);
  localparam logic [CW-1:0] NORM_MAX  = CW'(W - 1);

  localparam logic [2:0] D_P1 = 3'b001;
  localparam logic [2:0] D_P2 = 3'b010;
  localparam logic [2:0] D_M1 = 3'b101;
  localparam logic [2:0] D_M2 = 3'b110;

  typedef enum logic [4:0] {
    S_IDLE     = 5'd0,
    S_LOAD_A   = 5'd1,
    S_LOAD_B   = 5'd2,
    S_CHECK    = 5'd3,
    S_NORM     = 5'd4,
    S_SEL      = 5'd5,
    S_ADD      = 5'd6,
    S_ITER     = 5'd7,
    S_CORR_CHK = 5'd8,
    S_CORR     = 5'd9,
    S_CONV     = 5'd10,
    S_DENORM   = 5'd11,
    S_OUT_Q    = 5'd12,
    S_OUT_R    = 5'd13,
    S_DONE     = 5'd14,
    S_DBZ      = 5'd15
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_iter;
  logic [CW-1:0] r_den;
  logic [CW-1:0] r_norm;
  logic          r_dbz;
  logic [2:0]    r_digit;

  logic [4:0]  w_code;
  logic        w_abort;
  logic        w_digit_nz;
  logic [16:0] w_ctl;
  logic        w_end;

  assign w_code     = r_state;
  assign w_abort    = abort && (r_state != S_IDLE);
  assign w_digit_nz = (qdigit == D_P1) || (qdigit == D_P2) ||
                      (qdigit == D_M1) || (qdigit == D_M2);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_ctl = '0;
    w_end = 1'b0;
    case (r_state)
      S_LOAD_A:   w_ctl[0] = 1'b1;
      S_LOAD_B:   w_ctl[1] = 1'b1;
      S_NORM:     w_ctl[2] = 1'b1;
      S_SEL: begin
        w_ctl[3] = 1'b1;
        w_ctl[4] = (qdigit == D_P1);
        w_ctl[5] = (qdigit == D_M1);
        w_ctl[6] = (qdigit == D_M2);
        w_ctl[7] = (qdigit == D_P2);
      end
      // A positive digit subtracts the divisor multiple, |digit|=2 selects 2B.
      S_ADD: begin
        w_ctl[8]  = 1'b1;
        w_ctl[9]  = (r_digit == D_P1) || (r_digit == D_P2);
        w_ctl[10] = (r_digit == D_P2) || (r_digit == D_M2);
      end
      S_ITER:     w_ctl[11] = (r_iter != LAST_ITER);
      S_CORR: begin
        w_ctl[8]  = 1'b1;
        w_ctl[13] = 1'b1;
      end
      S_CONV:     w_ctl[12] = 1'b1;
      S_DENORM:   w_ctl[14] = (r_den != '0);
      S_OUT_Q:    w_ctl[15] = 1'b1;
      S_OUT_R:    w_ctl[16] = 1'b1;
      S_DONE:     w_end = 1'b1;
      S_DBZ:      w_end = 1'b1;
      default: begin
        w_ctl = '0;
        w_end = 1'b0;
      end
    endcase
    if (w_abort) begin
      w_ctl = '0;
      w_end = 1'b0;
    end
  end

  assign control_signals = w_ctl;
  assign endSignal       = w_end;
  assign busy            = (w_code != 5'd0) && !w_code[4];
  assign dbz             = r_dbz;
  assign state           = w_code;
  assign norm_cnt        = r_norm;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_den   <= '0;
      r_norm  <= '0;
      r_dbz   <= 1'b0;
      r_digit <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_den   <= '0;
    end else begin
      case (r_state)
        // Counters and the flag are cleared as LOAD_A is entered, so they read 0 throughout it.
        S_IDLE: if (beginSignal) begin
          r_state <= S_LOAD_A;
          r_iter  <= '0;
          r_norm  <= '0;
          r_dbz   <= 1'b0;
        end
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: r_state <= S_CHECK;
        S_CHECK: begin
          if (b_zero) begin
            r_state <= S_DBZ;
            r_dbz   <= 1'b1;
          end else if (b_msb) begin
            r_state <= S_SEL;
          end else if (r_norm == NORM_MAX) begin
            r_state <= S_DBZ;
            r_dbz   <= 1'b1;
          end else begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_norm  <= r_norm + 1'b1;
          r_state <= S_CHECK;
        end
        S_SEL: begin
          r_digit <= qdigit;
          r_state <= w_digit_nz ? S_ADD : S_ITER;
        end
        S_ADD: r_state <= S_ITER;
        S_ITER: begin
          if (r_iter == LAST_ITER) begin
            r_state <= S_CORR_CHK;
          end else begin
            r_iter  <= r_iter + 1'b1;
            r_state <= S_SEL;
          end
        end
        S_CORR_CHK: r_state <= p_sign ? S_CORR : S_CONV;
        S_CORR:     r_state <= S_CONV;
        S_CONV: begin
          r_den   <= r_norm;
          r_state <= S_DENORM;
        end
        S_DENORM: begin
          if (r_den == '0) r_state <= S_OUT_Q;
          else             r_den   <= r_den - 1'b1;
        end
        S_OUT_Q: r_state <= S_OUT_R;
        S_OUT_R: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        S_DBZ:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srt4_cu_param.sv
// Bench for srt4_cu_param: a transaction-level model expands each division into its expected
// per-cycle trace (W=8 and W=16 instances), and one compare process checks the DUT every cycle.
module tb_srt4_cu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b, begin8, begin16, abort, b_msb, b_zero, p_sign;
  logic [2:0] qdigit;

  logic        busy8, end8, dbz8;
  logic [4:0]  state8;
  logic [2:0]  nc8;
  logic [16:0] ctl8;
  logic        busy16, end16, dbz16;
  logic [4:0]  state16;
  logic [3:0]  nc16;
  logic [16:0] ctl16;

  srt4_cu_param #(.W(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .beginSignal(begin8), .abort(abort), .b_msb(b_msb),
    .b_zero(b_zero), .qdigit(qdigit), .p_sign(p_sign), .busy(busy8), .endSignal(end8),
    .dbz(dbz8), .state(state8), .norm_cnt(nc8), .control_signals(ctl8));

  srt4_cu_param #(.W(16)) dut16 (
    .clk(clk), .rst_b(rst_b), .beginSignal(begin16), .abort(abort), .b_msb(b_msb),
    .b_zero(b_zero), .qdigit(qdigit), .p_sign(p_sign), .busy(busy16), .endSignal(end16),
    .dbz(dbz16), .state(state16), .norm_cnt(nc16), .control_signals(ctl16));

  logic        sel16;
  logic [4:0]  o_state;
  logic [16:0] o_ctl;
  logic        o_end, o_busy, o_dbz;
  logic [3:0]  o_nc;
  assign o_state = sel16 ? state16 : state8;
  assign o_ctl   = sel16 ? ctl16   : ctl8;
  assign o_end   = sel16 ? end16   : end8;
  assign o_busy  = sel16 ? busy16  : busy8;
  assign o_dbz   = sel16 ? dbz16   : dbz8;
  assign o_nc    = sel16 ? nc16    : {1'b0, nc8};

  typedef struct {
    logic [4:0]  st;
    logic [16:0] ctl;
    logic        en, busy, dbz;
    logic [3:0]  nc;
    logic        beg, ab, msb, bz, ps;
    logic [2:0]  qd;
  } cyc_t;

  cyc_t       tr[$];
  cyc_t       exp_c;
  bit         exp_valid = 1'b0;
  int         cur_cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         t_cnt[17];
  int         t_busy, t_end;
  logic [2:0] p_dig[8];
  bit         m_dbz[2];
  int         m_nc[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [16:0] b(input int k);
    return 17'(1) << k;
  endfunction

  function automatic int dval(input logic [2:0] q);
    case (q)
      3'b001: return 1;
      3'b010: return 2;
      3'b101: return -1;
      3'b110: return -2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [16:0] digit_strobe(input int v);
    case (v)
      1:  return b(4);
      -1: return b(5);
      -2: return b(6);
      2:  return b(7);
      default: return '0;
    endcase
  endfunction

  // One busy cycle with don't-care inputs randomised.
  function automatic cyc_t mk(input int st, input logic [16:0] ctl, input int nc, input bit dz);
    cyc_t c;
    c.st = 5'(st); c.ctl = ctl; c.en = 1'b0; c.busy = 1'b1; c.dbz = dz; c.nc = 4'(nc);
    c.beg = 1'($urandom); c.ab = 1'b0; c.msb = 1'($urandom); c.bz = 1'($urandom);
    c.ps = 1'($urandom); c.qd = 3'($urandom);
    return c;
  endfunction

  function automatic cyc_t idle_rec(input int s);
    cyc_t c;
    c = mk(0, '0, m_nc[s], m_dbz[s]);
    c.busy = 1'b0; c.beg = 1'b0; c.ab = 1'($urandom);
    return c;
  endfunction

  // Expand one division (cycles 1..end) from the algorithm's phases.
  task automatic build_trace(input int w, input bit bz, input int nsh, input bit ps);
    cyc_t c;
    int   v, v_d;
    tr.delete();
    tr.push_back(mk(1, b(0), 0, 1'b0));
    tr.push_back(mk(2, b(1), 0, 1'b0));
    v = 0;
    forever begin
      c = mk(3, '0, v, 1'b0);
      c.bz = bz;
      c.msb = (v >= nsh);
      tr.push_back(c);
      if (bz || (v < nsh && v == w - 1)) begin
        c = mk(15, '0, v, 1'b1);
        c.en = 1'b1;
        tr.push_back(c);
        return;
      end
      if (v >= nsh) break;
      tr.push_back(mk(4, b(2), v, 1'b0));
      v++;
    end
    for (int i = 0; i < w / 2; i++) begin
      v_d = dval(p_dig[i]);
      c = mk(5, b(3) | digit_strobe(v_d), v, 1'b0);
      c.qd = p_dig[i];
      tr.push_back(c);
      if (v_d != 0)
        tr.push_back(mk(6, b(8) | (v_d > 0 ? b(9) : '0) | (v_d == 2 || v_d == -2 ? b(10) : '0),
                        v, 1'b0));
      tr.push_back(mk(7, (i < w / 2 - 1) ? b(11) : '0, v, 1'b0));
    end
    c = mk(8, '0, v, 1'b0);
    c.ps = ps;
    tr.push_back(c);
    if (ps) tr.push_back(mk(9, b(8) | b(13), v, 1'b0));
    tr.push_back(mk(10, b(12), v, 1'b0));
    for (int k = 0; k < v; k++) tr.push_back(mk(11, b(14), v, 1'b0));
    tr.push_back(mk(11, '0, v, 1'b0));
    tr.push_back(mk(12, b(15), v, 1'b0));
    tr.push_back(mk(13, b(16), v, 1'b0));
    c = mk(14, '0, v, 1'b0);
    c.en = 1'b1;
    tr.push_back(c);
  endtask

  task automatic drive(input cyc_t c);
    @(posedge clk);
    #1;
    begin8  = c.beg & ~sel16;
    begin16 = c.beg & sel16;
    abort   = c.ab;
    b_msb   = c.msb;
    b_zero  = c.bz;
    qdigit  = c.qd;
    p_sign  = c.ps;
    exp_c   = c;
    exp_valid = 1'b1;
    cur_cyc++;
    @(negedge clk);
    #1;
  endtask

  // abort_at: 0 none, -1 random, else cycle index; stop_at: 0 run to the end.
  task automatic run_trans(input bit s16, input bit bz, input int nsh, input bit ps,
                           input bit ab_beg, input int abort_at, input int stop_at);
    cyc_t c;
    int   s, ab_i, len;
    s = s16 ? 1 : 0;
    sel16 = s16;
    build_trace(s16 ? 16 : 8, bz, nsh, ps);
    ab_i = (abort_at < 0) ? 1 + int'($urandom_range(0, tr.size() - 1)) : abort_at;
    if (ab_i > 0 && ab_i <= tr.size()) begin
      while (tr.size() > ab_i) void'(tr.pop_back());
      c = tr[ab_i - 1];
      c.ctl = '0; c.en = 1'b0; c.ab = 1'b1;
      tr[ab_i - 1] = c;
    end
    for (int k = 0; k < 17; k++) t_cnt[k] = 0;
    t_busy = 0;
    t_end = -1;
    cur_cyc = -1;
    c = idle_rec(s);
    c.beg = 1'b1;
    c.ab = ab_beg;
    drive(c);
    len = (stop_at > 0 && stop_at < tr.size()) ? stop_at : tr.size();
    for (int i = 0; i < len; i++) drive(tr[i]);
    m_dbz[s] = tr[len - 1].dbz;
    m_nc[s]  = int'(tr[len - 1].nc);
  endtask

  task automatic idle_gap(input int k);
    for (int i = 0; i < k; i++) drive(idle_rec(sel16 ? 1 : 0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    rst_b = 1'b0;
    begin8 = 1'b0; begin16 = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset w8 outputs",  32'({state8, ctl8, end8, busy8, dbz8, nc8}), 32'd0);
    check("reset w16 outputs", 32'({state16, ctl16, end16, busy16, dbz16, nc16}), 32'd0);
    #1;
    rst_b = 1'b1;
    m_dbz[0] = 1'b0; m_dbz[1] = 1'b0;
    m_nc[0] = 0; m_nc[1] = 0;
  endtask

  task automatic set_dig(input logic [2:0] d_even, input logic [2:0] d_odd);
    for (int i = 0; i < 8; i++) p_dig[i] = (i % 2 == 0) ? d_even : d_odd;
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check($sformatf("state cyc%0d", cur_cyc), 32'(o_state), 32'(exp_c.st));
      check($sformatf("ctl cyc%0d", cur_cyc), 32'(o_ctl), 32'(exp_c.ctl));
      check($sformatf("end/busy/dbz/nc cyc%0d", cur_cyc), 32'({o_end, o_busy, o_dbz, o_nc}),
            32'({exp_c.en, exp_c.busy, exp_c.dbz, exp_c.nc}));
      for (int k = 0; k < 17; k++) if (o_ctl[k]) t_cnt[k]++;
      if (o_busy) t_busy++;
      if (o_end && t_end < 0) t_end = cur_cyc;
    end
  end

  initial begin
    rst_b = 1'b0; sel16 = 1'b0;
    begin8 = 1'b0; begin16 = 1'b0; abort = 1'b0;
    b_msb = 1'b0; b_zero = 1'b0; qdigit = '0; p_sign = 1'b0;
    do_reset();

    // Nominal W=8: normalised divisor, all digits +1, no correction.
    set_dig(3'b001, 3'b001);
    run_trans(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    check("nominal trace length", 32'(tr.size()), 32'd21);
    check("nominal end cycle", 32'(t_end), 32'd21);
    check("nominal busy cycles", 32'(t_busy), 32'd21);
    check("nominal c3", 32'(t_cnt[3]), 32'd4);
    check("nominal c4", 32'(t_cnt[4]), 32'd4);
    check("nominal c8", 32'(t_cnt[8]), 32'd4);
    check("nominal c9", 32'(t_cnt[9]), 32'd4);
    check("nominal c10", 32'(t_cnt[10]), 32'd0);
    check("nominal c11", 32'(t_cnt[11]), 32'd3);
    check("nominal c2+c13+c14", 32'(t_cnt[2] + t_cnt[13] + t_cnt[14]), 32'd0);

    // Normalisation by 3 with zero digits and a negative remainder, issued back to back.
    set_dig(3'b000, 3'b000);
    run_trans(1'b0, 1'b0, 3, 1'b1, 1'b0, 0, 0);
    check("norm end cycle", 32'(t_end), 32'd27);
    check("norm c2", 32'(t_cnt[2]), 32'd3);
    check("norm c14", 32'(t_cnt[14]), 32'd3);
    check("norm c13", 32'(t_cnt[13]), 32'd1);
    check("norm norm_cnt", 32'(o_nc), 32'd3);
    idle_gap(1);

    // Divide by zero, then a new start clears the flag.
    run_trans(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    check("dbz end cycle", 32'(t_end), 32'd4);
    check("dbz flag", 32'(o_dbz), 32'd1);
    check("dbz state", 32'(o_state), 32'd15);
    idle_gap(2);
    run_trans(1'b0, 1'b0, 3, 1'b0, 1'b0, 0, 6);
    check("restart state", 32'(o_state), 32'd4);
    check("restart dbz cleared", 32'(o_dbz), 32'd0);
    check("restart norm_cnt", 32'(o_nc), 32'd1);
    do_reset();

    // Abort in the second ADD, then a fresh start with abort also high in IDLE.
    set_dig(3'b001, 3'b001);
    run_trans(1'b0, 1'b0, 0, 1'b0, 1'b0, 8, 0);
    check("abort state", 32'(o_state), 32'd6);
    check("abort ctl", 32'(o_ctl), 32'd0);
    idle_gap(1);
    check("abort busy", 32'(o_busy), 32'd0);
    run_trans(1'b0, 1'b0, 0, 1'b0, 1'b1, 0, 0);
    check("after abort end cycle", 32'(t_end), 32'd21);

    // W=16 with digits alternating +2 / -2.
    set_dig(3'b010, 3'b110);
    run_trans(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    check("w16 end cycle", 32'(t_end), 32'd33);
    check("w16 c10", 32'(t_cnt[10]), 32'd8);
    check("w16 c9", 32'(t_cnt[9]), 32'd4);
    check("w16 c7", 32'(t_cnt[7]), 32'd4);
    check("w16 c6", 32'(t_cnt[6]), 32'd4);

    // Sticky dbz cleared by reset.
    run_trans(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    idle_gap(1);
    do_reset();

    // Randomised divisions on both widths.
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 8; i++) p_dig[i] = 3'($urandom);
      run_trans(1'($urandom), ($urandom % 8) == 0, int'($urandom % 4), 1'($urandom),
                1'($urandom), (($urandom % 4) == 0) ? -1 : 0, 0);
      idle_gap(int'($urandom % 3));
    end

    exp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
